// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter holding the grant for a whole bus cycle.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = 4,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,

  output logic [1:0]    gnt_o,
  output logic          timeout_o
);

  // Handshake: a beat completes when s_stb_o and (s_ack_i or s_err_i) are high in the
  // same cycle; responses seen while s_stb_o is low are dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;

  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;
  logic [SW-1:0] g_sel;
  logic          g_we, g_cyc, g_stb;
  logic          to_hit;
  logic          fwd_ack, fwd_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // On a release the waiting master is taken over directly, skipping IDLE.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_d = ((FIXED_PRIO != 0) || last_gnt_q) ? GNT0 : GNT1;
        else if (m0_cyc_i)
          state_d = GNT0;
        else if (m1_cyc_i)
          state_d = GNT1;
      end
      GNT0:    if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      GNT1:    if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0) last_gnt_d = 1'b0;
    if (state_d == GNT1) last_gnt_d = 1'b1;
  end

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    gnt_o = 2'b00;
    case (state_q)
      GNT0: begin
        g_adr = m0_adr_i;
        g_dat = m0_dat_i;
        g_sel = m0_sel_i;
        g_we  = m0_we_i;
        g_cyc = m0_cyc_i;
        g_stb = m0_stb_i;
        gnt_o = 2'b01;
      end
      GNT1: begin
        g_adr = m1_adr_i;
        g_dat = m1_dat_i;
        g_sel = m1_sel_i;
        g_we  = m1_we_i;
        g_cyc = m1_cyc_i;
        g_stb = m1_stb_i;
        gnt_o = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q;
  logic        stall;

  assign stall    = g_stb & ~s_ack_i & ~s_err_i;
  assign to_hit   = stall & (to_cnt_q == TO_LAST);
  assign to_cnt_d = (stall && !to_hit) ? to_cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_q | to_hit;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_hit    = 1'b0;
  // Constant 0 for every legal TIMEOUT_CYCLES value.
  assign timeout_o = (TIMEOUT_CYCLES == 0);
`endif

  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = g_cyc;
  assign s_stb_o = g_stb & ~to_hit;

  assign fwd_ack = s_ack_i & s_stb_o;
  assign fwd_err = (s_err_i & s_stb_o) | to_hit;

  assign m0_ack_o = gnt_o[0] & fwd_ack;
  assign m0_err_o = gnt_o[0] & fwd_err;
  assign m0_dat_o = gnt_o[0] ? s_dat_i : '0;
  assign m1_ack_o = gnt_o[1] & fwd_ack;
  assign m1_err_o = gnt_o[1] & fwd_err;
  assign m1_dat_o = gnt_o[1] ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: memory slave model, master driver tasks, grant-order model
// and transaction-level memory scoreboard.
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] rdat_v [2];
  logic [1:0]  ack_v, err_v;

  logic [31:0] s_adr, s_wdat, rdat_q;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, ack_q, err_q;
  logic [1:0]  gnt;
  logic        tmo;
  logic        err_en, stall_en;

  logic [31:0] fp_adr, fp_wdat, fp_rd0, fp_rd1;
  logic [3:0]  fp_sel;
  logic        fp_we, fp_cyc, fp_stb, fp_tmo;
  logic [1:0]  fp_ack, fp_err, fp_gnt;

  wb_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(rdat_v[0]), .m0_ack_o(ack_v[0]), .m0_err_o(err_v[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(rdat_v[1]), .m1_ack_o(ack_v[1]), .m1_err_o(err_v[1]),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(rdat_q), .s_ack_i(ack_q), .s_err_i(err_q),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  // Fixed-priority twin: sees the same masters, only its first grant per round is checked.
  wb_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) u_fp (
    .clk(clk), .rst(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(fp_rd0), .m0_ack_o(fp_ack[0]), .m0_err_o(fp_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(fp_rd1), .m1_ack_o(fp_ack[1]), .m1_err_o(fp_err[1]),
    .s_adr_o(fp_adr), .s_dat_o(fp_wdat), .s_sel_o(fp_sel), .s_we_o(fp_we),
    .s_cyc_o(fp_cyc), .s_stb_o(fp_stb),
    .s_dat_i(32'h0), .s_ack_i(1'b0), .s_err_i(1'b0),
    .gnt_o(fp_gnt), .timeout_o(fp_tmo)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // Memory slave: registered ack/err one cycle after a strobe, so every beat takes 2 cycles.
  logic [31:0] mem [256];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= 32'h0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      ack_q  <= s_cyc & s_stb & ~ack_q & ~err_q & ~err_en & ~stall_en;
      err_q  <= s_cyc & s_stb & ~ack_q & ~err_q & err_en;
      rdat_q <= mem[s_adr[9:2]];
      if (s_cyc && s_stb && s_we && !ack_q && !err_q && !err_en && !stall_en)
        for (int k = 0; k < 4; k++)
          if (s_sel[k]) mem[s_adr[9:2]][8*k +: 8] <= s_wdat[8*k +: 8];
    end
  end

  logic [1:0]  gnt_hist [$];
  logic [1:0]  prev_gnt = 2'b00;
  always @(negedge clk) begin
    if (gnt !== prev_gnt) begin
      gnt_hist.push_back(gnt);
      prev_gnt = gnt;
    end
  end

  logic [31:0] ref_mem [256];
  int          last_served;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_hist(input logic [1:0] exp_q [$]);
    check("hist_len", 64'(gnt_hist.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gnt_hist.size(); i++)
      check("hist_gnt", 64'(gnt_hist[i]), 64'(exp_q[i]));
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // One full bus cycle for master m: beats consecutive words from base, optional stb-low gaps.
  task automatic bus_cycle(input int m, input bit we, input logic [31:0] base,
                           input int beats, input bit gaps, output int nerr);
    int          idx, w;
    logic [31:0] d;
    logic [3:0]  sel;
    nerr = 0;
    m_cyc[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      d   = $urandom;
      sel = we ? 4'($urandom_range(1, 15)) : 4'hF;
      m_adr[m] = base + 32'(4 * b);
      m_dat[m] = d;
      m_sel[m] = sel;
      m_we[m]  = we;
      m_stb[m] = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!ack_v[m] && !err_v[m] && w < 200);
      check("beat_done", 64'(ack_v[m] | err_v[m]), 64'd1);
      check("other_quiet", 64'({ack_v[1-m], err_v[1-m], rdat_v[1-m]}), 64'd0);
      idx = int'(base[9:2]) + b;
      if (ack_v[m]) begin
        if (we) begin
          for (int k = 0; k < 4; k++)
            if (sel[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
        end else begin
          check("rdata", 64'(rdat_v[m]), 64'(ref_mem[idx]));
        end
      end
      if (err_v[m]) nerr++;
      if (gaps && b < beats - 1) begin
        m_stb[m] = 1'b0;
        #1 check("ack_gated", 64'(ack_v[m] | err_v[m]), 64'd0);
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end
    m_stb[m] = 1'b0;
    m_cyc[m] = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: m0 alone, 1: m1 alone, 2: both raise cyc together.
  task automatic run_round(input int mode);
    int          w, ne0, ne1, bt0, bt1;
    bit          we0, we1, gp0, gp1;
    logic [31:0] b0, b1;
    logic [1:0]  exp_q [$];
    gnt_hist.delete();
    w = (mode == 2) ? 1 - last_served : mode;
    exp_q.push_back(onehot(w));
    if (mode == 2) exp_q.push_back(onehot(1 - w));
    exp_q.push_back(2'b00);
    last_served = (mode == 2) ? 1 - w : w;
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    gp0 = 1'($urandom_range(0, 1));
    gp1 = 1'($urandom_range(0, 1));
    bt0 = $urandom_range(1, 4);
    bt1 = $urandom_range(1, 4);
    b0  = 32'($urandom_range(0, 60)) * 32'd4;
    b1  = 32'h200 + 32'($urandom_range(0, 60)) * 32'd4;
    fork
      if (mode != 1) bus_cycle(0, we0, b0, bt0, gp0, ne0);
      if (mode != 0) bus_cycle(1, we1, b1, bt1, gp1, ne1);
      begin
        @(negedge clk);
        check("gnt_first", 64'(gnt), 64'(onehot(w)));
        check("arb_latency", 64'(s_cyc), 64'd1);
        if (mode == 2) check("fp_prio", 64'(fp_gnt), 64'(2'b01));
      end
    join
    @(negedge clk);
    #1 check_hist(exp_q);
  endtask

  int          w, ne;
  logic [1:0]  exp_q [$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
      m_we[i]  = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
    end
    err_en = 1'b0;
    stall_en = 1'b0;
    reset_ref();
    last_served = 1;

    repeat (3) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_s", 64'({s_cyc, s_stb, s_we, s_sel, s_adr}), 64'd0);
    check("rst_s_dat", 64'(s_wdat), 64'd0);
    check("rst_m", 64'({ack_v, err_v, rdat_v[0], rdat_v[1]}), 64'd0);
    check("rst_tmo", 64'(tmo), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // m0 single write
    gnt_hist.delete();
    m_adr[0] = 32'h100; m_dat[0] = 32'hDEAD_BEEF; m_sel[0] = 4'hF; m_we[0] = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1 check("lat_pre", 64'(s_cyc), 64'd0);
    @(negedge clk);
    check("lat_cyc", 64'(s_cyc), 64'd1);
    check("gnt0", 64'(gnt), 64'(2'b01));
    check("pass_adr", 64'({s_adr, s_sel, s_we, s_stb}), 64'({32'h100, 4'hF, 1'b1, 1'b1}));
    check("pass_dat", 64'(s_wdat), 64'h0000_0000_DEAD_BEEF);
    w = 0;
    while (!ack_v[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("m0_ack", 64'(ack_v[0]), 64'd1);
    check("m1_quiet", 64'({ack_v[1], err_v[1], rdat_v[1]}), 64'd0);
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    ref_mem[64] = 32'hDEAD_BEEF;
    last_served = 0;
    @(negedge clk);
    check("mem_100", 64'(mem[64]), 64'h0000_0000_DEAD_BEEF);
    check("ack_once", 64'(ack_v[0]), 64'd0);
    check("idle_gnt", 64'(gnt), 64'd0);
    #1;

    // Contention rounds: winners must alternate, starting from m1 since m0 was last served.
    for (int r = 0; r < 4; r++) run_round(2);

    // m1 4-beat read of 0x200..0x20C; m0 arrives mid-cycle and waits.
    gnt_hist.delete();
    fork
      bus_cycle(1, 1'b0, 32'h200, 4, 1'b0, ne);
      begin
        repeat (2) @(negedge clk);
        bus_cycle(0, 1'b1, 32'h40, 1, 1'b0, w);
      end
    join
    last_served = 0;
    @(negedge clk);
    #1;
    exp_q = '{2'b10, 2'b01, 2'b00};
    check_hist(exp_q);

    // Slave error on each beat of an m1 cycle.
    gnt_hist.delete();
    err_en = 1'b1;
    bus_cycle(1, 1'b1, 32'h300, 2, 1'b0, ne);
    err_en = 1'b0;
    last_served = 1;
    check("err_count", 64'(ne), 64'd2);
    @(negedge clk);
    #1;
    exp_q = '{2'b10, 2'b00};
    check_hist(exp_q);

    // Stalled slave on m0.
    stall_en = 1'b1;
    m_adr[0] = 32'h80; m_we[0] = 1'b0; m_sel[0] = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
      check("tmo_err", 64'(err_v[0]), 64'(k == 8));
      check("tmo_flag", 64'(tmo), 64'(k >= 9));
`else
      check("tmo_err", 64'(err_v[0]), 64'd0);
      check("tmo_flag", 64'(tmo), 64'd0);
`endif
      check("tmo_gnt", 64'(gnt), 64'(2'b01));
    end
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    last_served = 0;
    @(negedge clk);

    // Reset asserted mid-cycle while m1 holds the grant.
    m_adr[1] = 32'h204; m_we[1] = 1'b0; m_sel[1] = 4'hF;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_gnt", 64'(gnt), 64'(2'b10));
    check("pre_rst_cyc", 64'({s_cyc, s_stb}), 64'(2'b11));
    #2 rst = 1'b0;
    #1;
    check("async_rst_s", 64'({s_cyc, s_stb}), 64'd0);
    check("async_rst_gnt", 64'(gnt), 64'd0);
    check("async_rst_tmo", 64'(tmo), 64'd0);
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    stall_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    reset_ref();
    last_served = 1;
    #1;
    run_round(2);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) run_round($urandom_range(0, 2));

    check("end_idle", 64'(gnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
